// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl -- data-memory / serial-port controller for the CPU MEM stage.
//
// Accepts one access per req/ack handshake, decodes the latched address to
// RAM1, RAM2, UART data or UART status, and sequences the chip strobes for
// that target through SETUP -> ACCESS (WAIT_CYCLES clocks) -> DONE.
// The UART shares the RAM1 data bus; RAM1 stays disabled during UART access.
//
// Optional build macro UART_TX_BLOCK_EN: UART data writes wait in TXWAIT
// until the transmitter is empty (tbre & tsre) before strobing wrn.
//
// Ports:
//   clk, rst              clock (rising edge), synchronous active-low reset
//   req, we, addr, wdata  request handshake; operands sampled only in IDLE
//   rdata, ack, busy      read result (held until next read), done pulse,
//                         high whenever not IDLE
//   ram1_* / ram2_*       SRAM data bus, address and active-low en/oe/we
//   tbre, tsre            UART transmit buffer / shift register empty
//   data_ready            UART has a received byte
//   rdn, wrn              UART active-low read / write strobes
module mem_bus_ctrl #(
    parameter int unsigned       DATA_W         = 16,
    parameter int unsigned       ADDR_W         = 16,
    parameter int unsigned       SRAM_ADDR_W    = 18,
    parameter logic [ADDR_W-1:0] RAM1_UPPER     = 16'h8000,
    parameter logic [ADDR_W-1:0] UART_DATA_ADDR = 16'hBF00,
    parameter logic [ADDR_W-1:0] UART_STAT_ADDR = 16'hBF01,
    parameter int unsigned       WAIT_CYCLES    = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req,
    input  logic                   we,
    input  logic [ADDR_W-1:0]      addr,
    input  logic [DATA_W-1:0]      wdata,
    output logic [DATA_W-1:0]      rdata,
    output logic                   ack,
    output logic                   busy,
    inout  wire  [DATA_W-1:0]      ram1_data,
    output logic [SRAM_ADDR_W-1:0] ram1_addr,
    output logic                   ram1_en,
    output logic                   ram1_oe,
    output logic                   ram1_we,
    inout  wire  [DATA_W-1:0]      ram2_data,
    output logic [SRAM_ADDR_W-1:0] ram2_addr,
    output logic                   ram2_en,
    output logic                   ram2_oe,
    output logic                   ram2_we,
    input  logic                   tbre,
    input  logic                   tsre,
    input  logic                   data_ready,
    output logic                   rdn,
    output logic                   wrn
);

    // A zero wait count still needs one strobe cycle.
    localparam int unsigned WAIT_EFF = (WAIT_CYCLES == 0) ? 1 : WAIT_CYCLES;
    localparam int unsigned CNT_W    = (WAIT_EFF > 1) ? $clog2(WAIT_EFF) : 1;

`ifdef UART_TX_BLOCK_EN
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE, S_TXWAIT} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE} state_t;
`endif

    typedef enum logic [1:0] {T_RAM1, T_RAM2, T_UDATA, T_USTAT} target_t;

    function automatic target_t decode(input logic [ADDR_W-1:0] a);
        if (a < RAM1_UPPER)          return T_RAM1;
        else if (a == UART_DATA_ADDR) return T_UDATA;
        else if (a == UART_STAT_ADDR) return T_USTAT;
        else                          return T_RAM2;
    endfunction

    state_t           state;
    target_t          tgt;
    target_t          req_tgt;
    logic             we_q;
    logic [CNT_W-1:0] cnt;
    logic             drv1;
    logic             drv2;
    logic [DATA_W-1:0] dout1;
    logic [DATA_W-1:0] dout2;
    logic [DATA_W-1:0] uart_wdata;

    always_comb begin
        req_tgt    = decode(addr);
        uart_wdata = {{(DATA_W-8){1'b0}}, wdata[7:0]};
    end

    assign ram1_data = drv1 ? dout1 : 'z;
    assign ram2_data = drv2 ? dout2 : 'z;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            tgt       <= T_RAM1;
            we_q      <= 1'b0;
            cnt       <= '0;
            ack       <= 1'b0;
            busy      <= 1'b0;
            rdata     <= '0;
            ram1_addr <= '0;
            ram1_en   <= 1'b1;
            ram1_oe   <= 1'b1;
            ram1_we   <= 1'b1;
            ram2_addr <= '0;
            ram2_en   <= 1'b1;
            ram2_oe   <= 1'b1;
            ram2_we   <= 1'b1;
            rdn       <= 1'b1;
            wrn       <= 1'b1;
            drv1      <= 1'b0;
            drv2      <= 1'b0;
            dout1     <= '0;
            dout2     <= '0;
        end else begin
            ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        // Outputs registered here are what SETUP presents.
                        state <= S_SETUP;
                        busy  <= 1'b1;
                        tgt   <= req_tgt;
                        we_q  <= we;
                        cnt   <= CNT_W'(WAIT_EFF - 1);
                        case (req_tgt)
                            T_RAM1: begin
                                ram1_addr <= SRAM_ADDR_W'(addr);
                                ram1_en   <= 1'b0;
                                ram1_oe   <= we;
                                drv1      <= we;
                                dout1     <= wdata;
                            end
                            T_RAM2: begin
                                ram2_addr <= SRAM_ADDR_W'(addr);
                                ram2_en   <= 1'b0;
                                ram2_oe   <= we;
                                drv2      <= we;
                                dout2     <= wdata;
                            end
                            T_UDATA: begin
                                drv1  <= we;
                                dout1 <= uart_wdata;
                            end
                            default: ;  // status register: no bus activity
                        endcase
                    end
                end

                S_SETUP: begin
`ifdef UART_TX_BLOCK_EN
                    if (tgt == T_UDATA && we_q) begin
                        state <= S_TXWAIT;
                    end else
`endif
                    begin
                        state <= S_ACCESS;
                        case (tgt)
                            T_RAM1:  ram1_we <= ~we_q;
                            T_RAM2:  ram2_we <= ~we_q;
                            T_UDATA: begin
                                rdn <= we_q;
                                wrn <= ~we_q;
                            end
                            default: ;
                        endcase
                    end
                end

                S_ACCESS: begin
                    if (cnt == '0) begin
                        state   <= S_DONE;
                        ack     <= 1'b1;
                        ram1_en <= 1'b1;
                        ram1_oe <= 1'b1;
                        ram1_we <= 1'b1;
                        ram2_en <= 1'b1;
                        ram2_oe <= 1'b1;
                        ram2_we <= 1'b1;
                        rdn     <= 1'b1;
                        wrn     <= 1'b1;
                        if (!we_q) begin
                            case (tgt)
                                T_RAM1:  rdata <= ram1_data;
                                T_RAM2:  rdata <= ram2_data;
                                T_UDATA: rdata <= {{(DATA_W-8){1'b0}}, ram1_data[7:0]};
                                default: rdata <= {{(DATA_W-2){1'b0}}, data_ready, tbre & tsre};
                            endcase
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                S_DONE: begin
                    // Write data was held through DONE; release now.
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    drv1  <= 1'b0;
                    drv2  <= 1'b0;
                end

`ifdef UART_TX_BLOCK_EN
                S_TXWAIT: begin
                    if (tbre && tsre) begin
                        state <= S_ACCESS;
                        wrn   <= 1'b0;
                    end
                end
`endif

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Testbench for mem_bus_ctrl: SRAM and UART device models on the buses, a
// reference memory model keyed by CPU address, directed cases and random
// transactions. Build with UART_TX_BLOCK_EN to exercise the TXWAIT path.
module tb_mem_bus_ctrl;

    localparam int unsigned W = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        ack;
    logic        busy;
    wire  [15:0] ram1_data;
    wire  [15:0] ram2_data;
    logic [17:0] ram1_addr;
    logic [17:0] ram2_addr;
    logic        ram1_en, ram1_oe, ram1_we;
    logic        ram2_en, ram2_oe, ram2_we;
    logic        tbre, tsre, data_ready;
    logic        rdn, wrn;

    always #5 clk = ~clk;

    mem_bus_ctrl #(.WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ack(ack), .busy(busy),
        .ram1_data(ram1_data), .ram1_addr(ram1_addr), .ram1_en(ram1_en),
        .ram1_oe(ram1_oe), .ram1_we(ram1_we),
        .ram2_data(ram2_data), .ram2_addr(ram2_addr), .ram2_en(ram2_en),
        .ram2_oe(ram2_oe), .ram2_we(ram2_we),
        .tbre(tbre), .tsre(tsre), .data_ready(data_ready),
        .rdn(rdn), .wrn(wrn)
    );

    // ---------------- device models ----------------
    logic [15:0] mem1 [0:65535];
    logic [15:0] mem2 [0:65535];
    logic        mem_init = 1'b0;
    logic [15:0] uart_rx;
    logic [15:0] uart_tx_seen = '0;

    assign ram1_data = (!ram1_en && !ram1_oe && ram1_we) ? mem1[ram1_addr[15:0]] :
                       (!rdn ? uart_rx : 16'hzzzz);
    assign ram2_data = (!ram2_en && !ram2_oe && ram2_we) ? mem2[ram2_addr[15:0]] : 16'hzzzz;

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 65536; i++) begin
                mem1[i] <= 16'(i) ^ 16'h5A5A;
                mem2[i] <= 16'(i) ^ 16'h5A5A;
            end
            mem_init <= 1'b1;
        end else begin
            if (!ram1_en && !ram1_we) mem1[ram1_addr[15:0]] <= ram1_data;
            if (!ram2_en && !ram2_we) mem2[ram2_addr[15:0]] <= ram2_data;
            if (!wrn) uart_tx_seen <= ram1_data;
        end
    end

    // Free-running low-cycle counters; transactions look at differences.
    int unsigned c_en1, c_oe1, c_we1, c_en2, c_oe2, c_we2, c_rdn, c_wrn, c_bad, c_ack;
    initial begin
        c_en1 = 0; c_oe1 = 0; c_we1 = 0; c_en2 = 0; c_oe2 = 0; c_we2 = 0;
        c_rdn = 0; c_wrn = 0; c_bad = 0; c_ack = 0;
    end
    always @(negedge clk) begin
        if (!ram1_en) c_en1++;
        if (!ram1_oe) c_oe1++;
        if (!ram1_we) c_we1++;
        if (!ram2_en) c_en2++;
        if (!ram2_oe) c_oe2++;
        if (!ram2_we) c_we2++;
        if (!rdn)     c_rdn++;
        if (!wrn)     c_wrn++;
        if (ack)      c_ack++;
        // strobes while idle, or two devices enabled on one bus
        if ((!busy && !(ram1_en && ram1_oe && ram1_we && ram2_en && ram2_oe && ram2_we && rdn && wrn)) ||
            (!ram1_en && (!rdn || !wrn)) || (!ram1_en && !ram2_en))
            c_bad++;
    end

    // ---------------- reference model ----------------
    logic [15:0] ref_mem [logic [15:0]];
    logic [15:0] exp_rd = '0;

    function automatic logic [15:0] ref_read(input logic [15:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : (a ^ 16'h5A5A);
    endfunction

    // 0 = RAM1, 1 = RAM2, 2 = UART data, 3 = UART status
    function automatic int tgt_of(input logic [15:0] a);
        if (a < 16'h8000) return 0;
        if (a == 16'hBF00) return 2;
        if (a == 16'hBF01) return 3;
        return 1;
    endfunction

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called and returns just after a falling edge with the DUT idle.
    task automatic do_access(input logic w, input logic [15:0] a, input logic [15:0] d);
        int          t;
        int unsigned n, exp_lat;
        int unsigned s_en1, s_oe1, s_we1, s_en2, s_oe2, s_we2, s_rdn, s_wrn, s_bad;
        logic [7:0]  el, rl, wl, ur, uw;
        logic [63:0] exp_cnt, cnt;

        t = tgt_of(a);
        s_en1 = c_en1; s_oe1 = c_oe1; s_we1 = c_we1; s_en2 = c_en2; s_oe2 = c_oe2;
        s_we2 = c_we2; s_rdn = c_rdn; s_wrn = c_wrn; s_bad = c_bad;

        exp_lat = W + 2;
`ifdef UART_TX_BLOCK_EN
        if (t == 2 && w) exp_lat = W + 3;
`endif
        if (!w) begin
            case (t)
                0, 1:    exp_rd = ref_read(a);
                2:       exp_rd = {8'h00, uart_rx[7:0]};
                default: exp_rd = {14'b0, data_ready, tbre & tsre};
            endcase
        end else if (t < 2) begin
            ref_mem[a] = d;
        end

        // en: SETUP + ACCESS; oe on reads: SETUP + ACCESS; we / uart strobes: ACCESS only
        el = 8'(W + 1);
        rl = w ? 8'd0 : 8'(W + 1);
        wl = w ? 8'(W) : 8'd0;
        ur = w ? 8'd0 : 8'(W);
        uw = w ? 8'(W) : 8'd0;
        case (t)
            0:       exp_cnt = {el, rl, wl, 40'd0};
            1:       exp_cnt = {24'd0, el, rl, wl, 16'd0};
            2:       exp_cnt = {48'd0, ur, uw};
            default: exp_cnt = 64'd0;
        endcase

        req = 1'b1; we = w; addr = a; wdata = d;
        @(negedge clk);
        // operands need not be held after acceptance
        req = 1'b0; we = 1'($urandom); addr = 16'($urandom); wdata = 16'($urandom);
        n = 1;
        while (!ack && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_eq("ack_latency", ack ? n : 0, exp_lat);
        check_eq("rdata", rdata, exp_rd);
        if (ack) begin
            check_eq("busy_done", busy, 1'b1);
            if (w && t == 0) check_eq("ram1_hold", ram1_data, d);
            if (w && t == 1) check_eq("ram2_hold", ram2_data, d);
            if (w && t == 2) check_eq("uart_hold", ram1_data, {8'h00, d[7:0]});
            if (t == 0) check_eq("ram1_addr", ram1_addr, {2'b00, a});
            if (t == 1) check_eq("ram2_addr", ram2_addr, {2'b00, a});
        end
        @(negedge clk);
        check_eq("ack_pulse", {ack, busy}, 2'b00);
        cnt = {8'(c_en1 - s_en1), 8'(c_oe1 - s_oe1), 8'(c_we1 - s_we1),
               8'(c_en2 - s_en2), 8'(c_oe2 - s_oe2), 8'(c_we2 - s_we2),
               8'(c_rdn - s_rdn), 8'(c_wrn - s_wrn)};
        check_eq("strobes", cnt, exp_cnt);
        check_eq("glitch", c_bad - s_bad, 0);
        if (w && t == 2) check_eq("uart_tx", uart_tx_seen, {8'h00, d[7:0]});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n, nacks, last, s_ack, s_bad, s_wrn;
        logic [15:0] a, d;
        logic        w;

        rst = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        tbre = 1'b1; tsre = 1'b1; data_ready = 1'b0; uart_rx = '0;
        repeat (4) @(negedge clk);
        check_eq("reset_state",
                 {ack, busy, rdata, ram1_addr, ram2_addr, ram1_en, ram1_oe, ram1_we,
                  ram2_en, ram2_oe, ram2_we, rdn, wrn},
                 {2'b00, 52'd0, 8'hFF});
        rst = 1'b1;
        @(negedge clk);

        // directed: RAM1 write/read, RAM2 read, UART data / status
        do_access(1'b1, 16'h0040, 16'hA5C3);
        do_access(1'b0, 16'h0040, 16'h0000);
        do_access(1'b1, 16'h9000, 16'h1234);
        do_access(1'b0, 16'h9000, 16'h0000);
        uart_rx = 16'hFF7E;
        do_access(1'b0, 16'hBF00, 16'h0000);
        check_eq("uart_rd_val", rdata, 16'h007E);
        data_ready = 1'b1; tbre = 1'b1; tsre = 1'b0;
        do_access(1'b0, 16'hBF01, 16'h0000);
        check_eq("uart_stat_val", rdata, 16'h0002);
        tsre = 1'b1;
        do_access(1'b1, 16'hBF01, 16'hFFFF);
        do_access(1'b1, 16'hBF00, 16'h0141);
        do_access(1'b0, 16'h7FFF, 16'h0000);
        do_access(1'b0, 16'h8000, 16'h0000);

        // handshake: req held continuously
        s_bad = c_bad;
        req = 1'b1; we = 1'b0; addr = 16'h0040;
        nacks = 0; last = 0;
        for (int unsigned i = 1; i <= 3 * (W + 3); i++) begin
            @(negedge clk);
            if (ack) begin
                if (nacks == 0) check_eq("hs_first", i, W + 2);
                else            check_eq("hs_spacing", i - last, W + 3);
                last = i;
                nacks++;
            end
        end
        req = 1'b0;
        check_eq("hs_count", nacks, 3);
        check_eq("hs_rdata", rdata, ref_read(16'h0040));
        exp_rd = ref_read(16'h0040);
        n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_eq("hs_idle", busy, 1'b0);
        check_eq("hs_glitch", c_bad - s_bad, 0);

        // reset in the middle of a RAM2 write
        s_ack = c_ack;
        req = 1'b1; we = 1'b1; addr = 16'hA000; wdata = 16'hC0DE;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        check_eq("rst_pre_we", ram2_we, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_strobes", {ram2_we, ram2_en, busy, ack}, 4'b1100);
        @(negedge clk);
        check_eq("rst_state2",
                 {ack, busy, rdata, ram1_addr, ram2_addr, ram1_en, ram1_oe, ram1_we,
                  ram2_en, ram2_oe, ram2_we, rdn, wrn},
                 {2'b00, 52'd0, 8'hFF});
        rst = 1'b1;
        exp_rd = '0;
        repeat (2 * (W + 3)) @(negedge clk);
        check_eq("rst_no_ack", c_ack - s_ack, 0);
        check_eq("rst_idle", busy, 1'b0);

`ifdef UART_TX_BLOCK_EN
        tbre = 1'b1; tsre = 1'b0; s_wrn = c_wrn;
        req = 1'b1; we = 1'b1; addr = 16'hBF00; wdata = 16'h0041;
        @(negedge clk);
        req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("txwait_hold", {wrn, busy, ack}, 3'b110);
        end
        tsre = 1'b1;
        n = 0;
        while (!ack && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_eq("txwait_ack", ack ? n : 0, W + 1);
        @(negedge clk);
        check_eq("txwait_wrn", c_wrn - s_wrn, W);
        check_eq("txwait_data", uart_tx_seen, 16'h0041);
`else
        s_wrn = c_wrn;
`endif

        // random transactions
        for (int k = 0; k < 150; k++) begin
            case ($urandom_range(0, 5))
                0, 1:    a = ($urandom_range(0, 7) == 0) ? 16'h7FFF : 16'($urandom_range(0, 255));
                2, 3: begin
                    case ($urandom_range(0, 7))
                        0:       a = 16'h8000;
                        1:       a = 16'hBEFF;
                        2:       a = 16'hBF02;
                        3:       a = 16'hFFFF;
                        default: a = 16'h9000 + 16'($urandom_range(0, 255));
                    endcase
                end
                4:       a = 16'hBF00;
                default: a = 16'hBF01;
            endcase
            w = 1'($urandom);
            d = 16'($urandom);
            uart_rx = 16'($urandom);
            data_ready = 1'($urandom);
            tbre = 1'($urandom);
            tsre = 1'($urandom);
`ifdef UART_TX_BLOCK_EN
            if (a == 16'hBF00 && w) begin
                tbre = 1'b1;
                tsre = 1'b1;
            end
`endif
            do_access(w, a, d);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
